// File: rtl/ahbsched_if.sv
// Burst request channel between the transfer scheduler
// and the AHB master interface.
interface ahbsched_if;
  logic [31:0] O_AHBSCHED_ADDR;
  logic [4:0]  O_AHBSCHED_COUNT;
  logic        O_AHBSCHED_WRITE;
  logic        O_AHBSCHED_START;
  logic        I_AHBSCHED_BEAT;

  modport master (
    output O_AHBSCHED_ADDR,
    output O_AHBSCHED_COUNT,
    output O_AHBSCHED_WRITE,
    output O_AHBSCHED_START,
    input  I_AHBSCHED_BEAT
  );

  modport slave (
    input  O_AHBSCHED_ADDR,
    input  O_AHBSCHED_COUNT,
    input  O_AHBSCHED_WRITE,
    input  O_AHBSCHED_START,
    output I_AHBSCHED_BEAT
  );
endinterface

// File: rtl/ahbsched.sv
// Rotate-job transfer scheduler: splits read and write
// streams into 1 KB-safe AHB bursts, round-robin between them.
module ahbsched #(
  parameter int BURST_MAX = 16,
  parameter int NW        = 16
) (
  input  logic          I_AHBSCHED_HCLK,
  input  logic          I_AHBSCHED_HRESET,
  input  logic          I_AHBSCHED_GO,
  input  logic          I_AHBSCHED_ABORT,
  input  logic [31:0]   I_AHBSCHED_SRC_ADDR,
  input  logic [31:0]   I_AHBSCHED_DST_ADDR,
  input  logic [NW-1:0] I_AHBSCHED_NWORDS,
  input  logic [2:0]    I_AHBSCHED_SIZE,
  input  logic [4:0]    I_AHBSCHED_RD_SPACE,
  input  logic [4:0]    I_AHBSCHED_WR_LEVEL,
  output logic          O_AHBSCHED_BUSY,
  output logic          O_AHBSCHED_DONE,
  ahbsched_if.master    bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  logic [2:0]    state;
  logic [31:0]   rd_addr;
  logic [31:0]   wr_addr;
  logic [NW-1:0] rd_rem;
  logic [NW-1:0] wr_rem;
  logic [4:0]    beat_cnt;
  logic [4:0]    len;
  logic          last_grant;
  logic          abort_pend;
  logic [1:0]    job_sz;
  logic [31:0]   out_addr;
  logic [4:0]    out_count;
  logic          out_write;

  logic [1:0]    go_sz;
  logic          rd_ok;
  logic          wr_ok;
  logic          pick_wr;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_rem;
  logic [31:0]   sel_fifo;
  logic [31:0]   bnd;
  logic [31:0]   raw;
  logic [4:0]    len_nxt;
  logic [31:0]   step;
  logic          last_beat;

  function automatic logic [31:0] align(
    input logic [31:0] a,
    input logic [1:0]  s
  );
    unique case (s)
      2'd0:    align = a;
      2'd1:    align = {a[31:1], 1'b0};
      default: align = {a[31:2], 2'b00};
    endcase
  endfunction

  // Pick the next stream and size its burst
  always_comb begin
    go_sz = (I_AHBSCHED_SIZE > 3'd2) ?
            2'd2 : I_AHBSCHED_SIZE[1:0];
    rd_ok = (rd_rem != '0) &&
            (I_AHBSCHED_RD_SPACE != 5'd0);
    wr_ok = (wr_rem != '0) &&
            (I_AHBSCHED_WR_LEVEL != 5'd0);
    pick_wr = (rd_ok && wr_ok) ? ~last_grant : wr_ok;
    sel_addr = pick_wr ? wr_addr : rd_addr;
    sel_rem  = pick_wr ? 32'(wr_rem) : 32'(rd_rem);
    sel_fifo = pick_wr ? 32'(I_AHBSCHED_WR_LEVEL)
                       : 32'(I_AHBSCHED_RD_SPACE);
    bnd = 32'((11'd1024 - {1'b0, sel_addr[9:0]})
              >> job_sz);
    raw = sel_rem;
    if (sel_fifo < raw) raw = sel_fifo;
    if (bnd < raw) raw = bnd;
    if (32'(BURST_MAX) < raw) raw = 32'(BURST_MAX);
    unique case (1'b1)
      (raw >= 32'd16):
        len_nxt = 5'd16;
      (raw >= 32'd8 && raw < 32'd16):
        len_nxt = 5'd8;
      (raw >= 32'd4 && raw < 32'd8):
        len_nxt = 5'd4;
      default:
        len_nxt = raw[4:0];
    endcase
    step = 32'(len) << job_sz;
    last_beat = bus.I_AHBSCHED_BEAT &&
                (beat_cnt == len - 5'd1);
  end

  // Job/burst sequencing and pointer bookkeeping
  always_ff @(posedge I_AHBSCHED_HCLK) begin
    if (I_AHBSCHED_HRESET) begin
      state      <= ST_IDLE;
      rd_addr    <= '0;
      wr_addr    <= '0;
      rd_rem     <= '0;
      wr_rem     <= '0;
      beat_cnt   <= '0;
      len        <= '0;
      last_grant <= 1'b1;
      abort_pend <= 1'b0;
      job_sz     <= '0;
      out_addr   <= '0;
      out_count  <= '0;
      out_write  <= 1'b0;
    end else begin
      if (state != ST_IDLE && I_AHBSCHED_ABORT)
        abort_pend <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (I_AHBSCHED_GO) begin
            rd_addr <= align(I_AHBSCHED_SRC_ADDR, go_sz);
            wr_addr <= align(I_AHBSCHED_DST_ADDR, go_sz);
            rd_rem     <= I_AHBSCHED_NWORDS;
            wr_rem     <= I_AHBSCHED_NWORDS;
            job_sz     <= go_sz;
            abort_pend <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            state <= (I_AHBSCHED_NWORDS == '0) ?
                     ST_FIN : ST_ARB;
          end
        end
        ST_ARB: begin
          if (abort_pend ||
              (rd_rem == '0 && wr_rem == '0)) begin
            state <= ST_FIN;
          end else if (rd_ok || wr_ok) begin
            len        <= len_nxt;
            out_addr   <= sel_addr;
            out_count  <= len_nxt;
            out_write  <= pick_wr;
            last_grant <= pick_wr;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          beat_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (last_beat) begin
            if (out_write) begin
              wr_addr <= wr_addr + step;
              wr_rem  <= wr_rem - NW'(len);
            end else begin
              rd_addr <= rd_addr + step;
              rd_rem  <= rd_rem - NW'(len);
            end
            beat_cnt <= '0;
            state    <= ST_ARB;
          end else if (bus.I_AHBSCHED_BEAT) begin
            beat_cnt <= beat_cnt + 5'd1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.O_AHBSCHED_ADDR  = out_addr;
  assign bus.O_AHBSCHED_COUNT = out_count;
  assign bus.O_AHBSCHED_WRITE = out_write;
  assign bus.O_AHBSCHED_START = (state == ST_ISSUE);
  assign O_AHBSCHED_BUSY      = (state != ST_IDLE);
  assign O_AHBSCHED_DONE      = (state == ST_FIN);

endmodule

// File: tb/tb_ahbsched.sv
// Bench for ahbsched: job-level model checked every cycle,
// plus literal burst lists for each directed job.
module tb_ahbsched;
  localparam int BMAX = 16;
  localparam int P_IDLE = 0;
  localparam int P_DEC  = 1;
  localparam int P_LNCH = 2;
  localparam int P_XFER = 3;
  localparam int P_FIN  = 4;

  typedef struct {
    logic [31:0] a;
    int          c;
    bit          w;
  } burst_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [15:0] nw = '0;
  logic [2:0]  size = '0;
  logic [4:0]  rd_sp = '0;
  logic [4:0]  wr_lv = '0;
  logic        busy;
  logic        done;

  int n_run = 0;
  int n_fail = 0;
  int done_seen = 0;
  int beat_mode = 0;
  bit chk_en = 1'b0;
  burst_t log_q[$];

  ahbsched_if bif();

  always #5 clk = ~clk;

  ahbsched #(.BURST_MAX(BMAX), .NW(16)) dut (
    .I_AHBSCHED_HCLK(clk),
    .I_AHBSCHED_HRESET(rst),
    .I_AHBSCHED_GO(go),
    .I_AHBSCHED_ABORT(abort),
    .I_AHBSCHED_SRC_ADDR(src),
    .I_AHBSCHED_DST_ADDR(dst),
    .I_AHBSCHED_NWORDS(nw),
    .I_AHBSCHED_SIZE(size),
    .I_AHBSCHED_RD_SPACE(rd_sp),
    .I_AHBSCHED_WR_LEVEL(wr_lv),
    .O_AHBSCHED_BUSY(busy),
    .O_AHBSCHED_DONE(done),
    .bus(bif)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Burst length from the rules: smallest limit, then
  // largest power of two >= 4 that fits, else the raw value.
  function automatic int plan_len(int rem, int fifo,
                                  logic [31:0] a, int sz);
    int raw;
    int bnd;
    int p;
    bnd = (1024 - int'(a % 1024)) >> sz;
    raw = rem;
    if (fifo < raw) raw = fifo;
    if (bnd < raw) raw = bnd;
    if (BMAX < raw) raw = BMAX;
    if (raw < 4) return raw;
    p = 4;
    while (p * 2 <= raw) p = p * 2;
    return p;
  endfunction

  function automatic logic [31:0] base_of(
    logic [31:0] a, int sz);
    return a & ~((32'd1 << sz) - 32'd1);
  endfunction

  int          m_ph = P_IDLE;
  logic [31:0] m_ra = '0;
  logic [31:0] m_wa = '0;
  int          m_rr = 0;
  int          m_wr = 0;
  int          m_sz = 0;
  int          m_len = 0;
  int          m_beats = 0;
  bit          m_lg = 1'b1;
  bit          m_ab = 1'b0;
  logic [31:0] m_oa = '0;
  int          m_oc = 0;
  bit          m_ow = 1'b0;

  // Reference job model, advanced on each clock edge
  always @(posedge clk) begin
    int prev;
    bit re;
    bit we;
    bit pw;
    if (rst) begin
      m_ph = P_IDLE;
      m_ra = '0; m_wa = '0;
      m_rr = 0; m_wr = 0; m_sz = 0;
      m_len = 0; m_beats = 0;
      m_lg = 1'b1; m_ab = 1'b0;
      m_oa = '0; m_oc = 0; m_ow = 1'b0;
    end else begin
      prev = m_ph;
      case (m_ph)
        P_IDLE: if (go) begin
          m_sz = (size > 3'd2) ? 2 : int'(size);
          m_ra = base_of(src, m_sz);
          m_wa = base_of(dst, m_sz);
          m_rr = int'(nw);
          m_wr = int'(nw);
          m_lg = 1'b1;
          m_ab = 1'b0;
          m_ph = (nw == 0) ? P_FIN : P_DEC;
        end
        P_DEC: begin
          if (m_ab || (m_rr == 0 && m_wr == 0)) begin
            m_ph = P_FIN;
          end else begin
            re = (m_rr > 0) && (rd_sp > 0);
            we = (m_wr > 0) && (wr_lv > 0);
            if (re || we) begin
              pw = (re && we) ? !m_lg : we;
              m_len = pw ?
                plan_len(m_wr, int'(wr_lv), m_wa, m_sz) :
                plan_len(m_rr, int'(rd_sp), m_ra, m_sz);
              m_oa = pw ? m_wa : m_ra;
              m_oc = m_len;
              m_ow = pw;
              m_lg = pw;
              m_beats = 0;
              m_ph = P_LNCH;
            end
          end
        end
        P_LNCH: m_ph = P_XFER;
        P_XFER: if (bif.I_AHBSCHED_BEAT) begin
          m_beats++;
          if (m_beats == m_len) begin
            if (m_ow) begin
              m_wa = m_wa + 32'(m_len << m_sz);
              m_wr = m_wr - m_len;
            end else begin
              m_ra = m_ra + 32'(m_len << m_sz);
              m_rr = m_rr - m_len;
            end
            m_ph = P_DEC;
          end
        end
        default: m_ph = P_IDLE;
      endcase
      if (prev != P_IDLE && abort) m_ab = 1'b1;
    end
  end

  // Every-cycle comparison of DUT outputs with the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_ph != P_IDLE));
      chk("done", 32'(done), 32'(m_ph == P_FIN));
      chk("start", 32'(bif.O_AHBSCHED_START),
          32'(m_ph == P_LNCH));
      chk("addr", bif.O_AHBSCHED_ADDR, m_oa);
      chk("count", 32'(bif.O_AHBSCHED_COUNT), 32'(m_oc));
      chk("write", 32'(bif.O_AHBSCHED_WRITE), 32'(m_ow));
    end
  end

  // Record launched bursts and job completions
  always @(negedge clk) begin
    if (chk_en && bif.O_AHBSCHED_START)
      log_q.push_back('{bif.O_AHBSCHED_ADDR,
                        int'(bif.O_AHBSCHED_COUNT),
                        bif.O_AHBSCHED_WRITE});
    if (chk_en && done) done_seen++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
    case (beat_mode)
      0: bif.I_AHBSCHED_BEAT = 1'b0;
      1: bif.I_AHBSCHED_BEAT = 1'b1;
      default:
        bif.I_AHBSCHED_BEAT = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(string nm, int lim);
    for (int k = 0; k < lim && !done; k++) tick();
    chk({nm, "_done_timeout"}, 32'(done), 32'd1);
    tick();
  endtask

  task automatic wait_start(string nm, int lim);
    for (int k = 0; k < lim && !bif.O_AHBSCHED_START; k++)
      tick();
    chk({nm, "_start_timeout"},
        32'(bif.O_AHBSCHED_START), 32'd1);
  endtask

  task automatic wait_log(string nm, int n, int lim);
    for (int k = 0; k < lim && log_q.size() < n; k++)
      tick();
    chk({nm, "_log_timeout"},
        32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic chk_burst(int i, logic [31:0] a,
                           int c, bit w);
    if (i >= log_q.size()) begin
      n_run++;
      n_fail++;
      $display("FAIL burst%0d: got none want %0h/%0d/%0d",
               i, a, c, w);
    end else begin
      chk($sformatf("burst%0d_addr", i), log_q[i].a, a);
      chk($sformatf("burst%0d_count", i),
          32'(log_q[i].c), 32'(c));
      chk($sformatf("burst%0d_write", i),
          32'(log_q[i].w), 32'(w));
    end
  endtask

  initial begin
    int d0;
    int cyc;
    bif.I_AHBSCHED_BEAT = 1'b0;
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // reset state, then an empty job
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_start", 32'(bif.O_AHBSCHED_START), 32'd0);
    chk("rst_addr", bif.O_AHBSCHED_ADDR, 32'd0);
    chk("rst_count", 32'(bif.O_AHBSCHED_COUNT), 32'd0);
    chk("rst_write", 32'(bif.O_AHBSCHED_WRITE), 32'd0);
    nw = 16'd0; size = 3'd2;
    pulse_go();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_done_off", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_nostart", 32'(log_q.size()), 32'd0);

    // alternating full bursts, GO mid-job ignored
    log_q.delete();
    src = 32'h1000; dst = 32'h2000; nw = 16'd32;
    size = 3'd2; rd_sp = 5'd16; wr_lv = 5'd16;
    beat_mode = 2;
    pulse_go();
    repeat (5) tick();
    src = 32'hDEAD0000;
    pulse_go();
    src = 32'h1000;
    wait_done("t2", 600);
    chk("t2_nbursts", 32'(log_q.size()), 32'd4);
    chk_burst(0, 32'h1000, 16, 1'b0);
    chk_burst(1, 32'h2000, 16, 1'b1);
    chk_burst(2, 32'h1040, 16, 1'b0);
    chk_burst(3, 32'h2040, 16, 1'b1);

    // 1 KB boundary split on reads, writes stalled
    log_q.delete();
    src = 32'h13F8; dst = 32'h2000; nw = 16'd8;
    rd_sp = 5'd16; wr_lv = 5'd0;
    pulse_go();
    wait_log("t3", 3, 300);
    repeat (10) tick();
    chk("t3_stalled", 32'(busy), 32'd1);
    chk("t3_nwrite", 32'(log_q.size()), 32'd3);
    wr_lv = 5'd16;
    wait_done("t3", 300);
    chk_burst(0, 32'h13F8, 2, 1'b0);
    chk_burst(1, 32'h1400, 4, 1'b0);
    chk_burst(2, 32'h1410, 2, 1'b0);
    chk_burst(3, 32'h2000, 8, 1'b1);

    // byte size, FIFO-limited lengths
    log_q.delete();
    src = 32'h3000; dst = 32'h4001; nw = 16'd7;
    size = 3'd0; rd_sp = 5'd5; wr_lv = 5'd0;
    pulse_go();
    wait_log("t4", 2, 300);
    repeat (10) tick();
    wr_lv = 5'd2;
    wait_done("t4", 400);
    chk("t4_nbursts", 32'(log_q.size()), 32'd6);
    chk_burst(0, 32'h3000, 4, 1'b0);
    chk_burst(1, 32'h3004, 3, 1'b0);
    chk_burst(2, 32'h4001, 2, 1'b1);
    chk_burst(3, 32'h4003, 2, 1'b1);
    chk_burst(4, 32'h4005, 2, 1'b1);
    chk_burst(5, 32'h4007, 1, 1'b1);

    // abort on the second beat of a 16-beat burst
    log_q.delete();
    beat_mode = 1;
    src = 32'h5000; dst = 32'h6000; nw = 16'd64;
    size = 3'd2; rd_sp = 5'd16; wr_lv = 5'd16;
    d0 = done_seen;
    pulse_go();
    wait_start("t5", 20);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cyc = 3;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("t5_start_to_done", 32'(cyc), 32'd18);
    tick();
    chk("t5_nbursts", 32'(log_q.size()), 32'd1);
    chk_burst(0, 32'h5000, 16, 1'b0);
    chk("t5_ndone", 32'(done_seen - d0), 32'd1);

    // reset in the middle of a burst, then restart
    log_q.delete();
    src = 32'h7000; dst = 32'h8000; nw = 16'd16;
    pulse_go();
    wait_start("t6", 20);
    repeat (4) tick();
    d0 = done_seen;
    rst = 1'b1;
    tick();
    chk("t6_busy_rst", 32'(busy), 32'd0);
    chk("t6_done_rst", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    chk("t6_no_done", 32'(done_seen - d0), 32'd0);
    log_q.delete();
    src = 32'h7003; size = 3'd3;
    abort = 1'b1;
    pulse_go();
    abort = 1'b0;
    wait_done("t6", 200);
    chk("t6_nbursts", 32'(log_q.size()), 32'd2);
    chk_burst(0, 32'h7000, 16, 1'b0);
    chk_burst(1, 32'h8000, 16, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
